prm_edge_scan_ctrl: RTL and testbench



---
 rtl/prm_edge_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_prm_edge_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_scan_ctrl.sv
// Purpose: sequences the shared PRM edge-checker bank over every group for each obstacle code, OR-accumulates blocked edges into a map, then streams the map out.
// Latency: per obstacle 1 accept + NUM_GRP scan + CHK_LAT drain cycles; output phase NUM_GRP cycles minimum, done one cycle after the last word handshake.
// Backpressure: obs_ready is high only while waiting for a code; out_* hold stable while out_ready is low; abort returns to IDLE from any state.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   start, abort                    begin a scan (IDLE only) / synchronous return to IDLE
//   obs_valid/obs_ready/obs_code/obs_last   obstacle code stream
//   chk_req/chk_code/chk_grp/chk_mask       checker bank request and fixed-latency result
//   out_valid/out_ready/out_grp/out_mask/out_last   blocked-edge map stream
//   busy, done, obs_cnt             status
module prm_edge_scan_ctrl #(
    parameter int CHK_W   = 32,
    parameter int NUM_GRP = 32,
    parameter int GRP_AW  = 5,
    parameter int CHK_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              obs_valid,
    output logic              obs_ready,
    input  logic [14:0]       obs_code,
    input  logic              obs_last,
    output logic              chk_req,
    output logic [14:0]       chk_code,
    output logic [GRP_AW-1:0] chk_grp,
    input  logic [CHK_W-1:0]  chk_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [GRP_AW-1:0] out_grp,
    output logic [CHK_W-1:0]  out_mask,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       obs_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OBS,
        S_SCAN,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam logic [GRP_AW-1:0] LAST_GRP = GRP_AW'(NUM_GRP - 1);

    state_t            state_q, state_d;
    logic [GRP_AW-1:0] grp_q, grp_d;      // scan group index
    logic [GRP_AW-1:0] idx_q, idx_d;      // output word index
    logic              last_q;            // current obstacle closes the set

    logic [CHK_W-1:0]  map_q [NUM_GRP];
    logic [CHK_W-1:0]  map_d [NUM_GRP];

    // Return tags: stage CHK_LAT-1 lines up with the cycle chk_mask is valid.
    logic              ret_vld [CHK_LAT];
    logic [GRP_AW-1:0] ret_grp [CHK_LAT];

    logic ret_due;
    logic [GRP_AW-1:0] ret_g;
    logic start_ok;
    logic obs_hs;
    logic out_hs;

    assign ret_due  = ret_vld[CHK_LAT-1];
    assign ret_g    = ret_grp[CHK_LAT-1];
    assign start_ok = (state_q == S_IDLE) && start && !abort;
    assign obs_hs   = (state_q == S_WAIT_OBS) && obs_valid && !abort;
    assign out_hs   = (state_q == S_OUT) && out_ready && !abort;

    // Next state and indices.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        idx_d   = idx_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_WAIT_OBS;
                end
                S_WAIT_OBS: begin
                    if (obs_valid) begin
                        state_d = S_SCAN;
                        grp_d   = '0;
                    end
                end
                S_SCAN: begin
                    if (grp_q == LAST_GRP) state_d = S_DRAIN;
                    else                   grp_d   = grp_q + 1'b1;
                end
                S_DRAIN: begin
                    // The final group's return is the last one in flight.
                    if (ret_due && (ret_g == LAST_GRP)) begin
                        state_d = last_q ? S_OUT : S_WAIT_OBS;
                        idx_d   = '0;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (idx_q == LAST_GRP) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Map update: cleared by start, OR-merged by tagged returns; abort drops the return of its cycle.
    always_comb begin
        for (int i = 0; i < NUM_GRP; i++) begin
            map_d[i] = map_q[i];
            if (start_ok) begin
                map_d[i] = '0;
            end else if (ret_due && !abort && (ret_g == GRP_AW'(i))) begin
                map_d[i] = map_q[i] | chk_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHK_LAT; k++) begin
                ret_vld[k] <= 1'b0;
                ret_grp[k] <= '0;
            end
        end else if (abort) begin
            for (int k = 0; k < CHK_LAT; k++) begin
                ret_vld[k] <= 1'b0;
                ret_grp[k] <= '0;
            end
        end else begin
            ret_vld[0] <= chk_req;
            ret_grp[0] <= chk_grp;
            for (int k = 1; k < CHK_LAT; k++) begin
                ret_vld[k] <= ret_vld[k-1];
                ret_grp[k] <= ret_grp[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grp_q     <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            for (int i = 0; i < NUM_GRP; i++) map_q[i] <= '0;
            obs_ready <= 1'b0;
            chk_req   <= 1'b0;
            chk_code  <= '0;
            out_valid <= 1'b0;
            out_grp   <= '0;
            out_mask  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            obs_cnt   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            idx_q   <= idx_d;
            map_q   <= map_d;

            if (obs_hs) begin
                chk_code <= obs_code;
                last_q   <= obs_last;
                if (obs_cnt != 16'hFFFF) obs_cnt <= obs_cnt + 16'd1;
            end else if (start_ok) begin
                obs_cnt <= '0;
            end

            // Outputs are registered from the next state so they line up with it.
            obs_ready <= (state_d == S_WAIT_OBS);
            chk_req   <= (state_d == S_SCAN);
            busy      <= (state_d != S_IDLE);
            out_valid <= (state_d == S_OUT);
            out_last  <= (state_d == S_OUT) && (idx_d == LAST_GRP);
            out_grp   <= idx_d;
            // map_d carries the final return written on the DRAIN exit edge.
            if (state_d == S_OUT) out_mask <= map_d[idx_d];
            done      <= out_hs && (idx_q == LAST_GRP);
        end
    end

    assign chk_grp = grp_q;

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
module tb_prm_edge_scan_ctrl;

    localparam int W   = 8;
    localparam int G   = 4;
    localparam int AW  = 2;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          obs_valid = 1'b0;
    logic          obs_ready;
    logic [14:0]   obs_code = '0;
    logic          obs_last = 1'b0;
    logic          chk_req;
    logic [14:0]   chk_code;
    logic [AW-1:0] chk_grp;
    logic [W-1:0]  chk_mask;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_grp;
    logic [W-1:0]  out_mask;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [15:0]   obs_cnt;

    prm_edge_scan_ctrl #(.CHK_W(W), .NUM_GRP(G), .GRP_AW(AW), .CHK_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_code(obs_code), .obs_last(obs_last),
        .chk_req(chk_req), .chk_code(chk_code), .chk_grp(chk_grp), .chk_mask(chk_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_grp(out_grp), .out_mask(out_mask),
        .out_last(out_last), .busy(busy), .done(done), .obs_cnt(obs_cnt)
    );

    always #5 clk = ~clk;

    // Bank model: mask = code[7:0]^grp when code[14] set, valid LAT cycles after the request.
    // Off-slot cycles carry junk that the controller must ignore.
    logic         b1_v, b2_v;
    logic [W-1:0] b1_m, b2_m;
    always @(posedge clk) begin
        b1_v <= chk_req;
        b1_m <= chk_code[14] ? (chk_code[7:0] ^ {6'b0, chk_grp}) : 8'h00;
        b2_v <= b1_v;
        b2_m <= b1_m;
    end
    assign chk_mask = b2_v ? b2_m : 8'hA5;

    int           n_test = 0;
    int           n_fail = 0;
    logic [7:0]   exp_map [G];
    int           exp_cnt = 0;
    logic [7:0]   got [G];
    int           hs_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_test++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output-side checker: every OUT cycle is compared with the model map, stalls must hold, done follows the 4th handshake.
    task automatic monitor();
        int         idx = 0;
        bit         dexp = 1'b0;
        bit         pst = 1'b0;
        logic [7:0] pm = '0;
        logic [1:0] pg = '0;
        logic       pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = 0; dexp = 1'b0; pst = 1'b0;
            end else begin
                chk("done", done, dexp);
                if (dexp) chk("busy_at_done", busy, 0);
                dexp = 1'b0;
                if (out_valid) begin
                    if (pst) begin
                        chk("hold_grp", out_grp, pg);
                        chk("hold_mask", out_mask, pm);
                        chk("hold_last", out_last, pl);
                    end
                    chk("out_grp", out_grp, idx);
                    chk("out_mask", out_mask, exp_map[idx]);
                    chk("out_last", out_last, idx == G - 1);
                    if (out_ready) begin
                        got[idx] = out_mask;
                        hs_cnt++;
                        pst = 1'b0;
                        if (idx == G - 1) begin dexp = 1'b1; idx = 0; end
                        else idx++;
                    end else begin
                        pst = 1'b1; pg = out_grp; pm = out_mask; pl = out_last;
                    end
                end else begin
                    idx = 0; pst = 1'b0;
                end
            end
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_obs_ready"}, obs_ready, 0);
        chk({tag, "_chk_req"},   chk_req,   0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_chk_code"},  chk_code,  0);
        chk({tag, "_chk_grp"},   chk_grp,   0);
        chk({tag, "_out_grp"},   out_grp,   0);
        chk({tag, "_out_mask"},  out_mask,  0);
        chk({tag, "_obs_cnt"},   obs_cnt,   0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < G; g++) exp_map[g] = '0;
        exp_cnt = 0;
    endtask

    // Returns right after the acceptance edge (for a last code) or once obs_ready is back (otherwise).
    task automatic send_obs(input logic [14:0] c, input logic l);
        int n = 0;
        logic [7:0] gb;
        obs_code = c; obs_last = l; obs_valid = 1'b1;
        while (!obs_ready && n < 20) begin tick(); n++; end
        if (!obs_ready) begin
            chk("obs_ready_timeout", 0, 1);
            obs_valid = 1'b0;
            return;
        end
        tick();
        obs_valid = 1'b0;
        exp_cnt++;
        if (c[14]) begin
            for (int g = 0; g < G; g++) begin
                gb = 8'(g);
                exp_map[g] = exp_map[g] | (c[7:0] ^ gb);
            end
        end
        if (!l) begin
            n = 0;
            while (!obs_ready && n < 20) begin tick(); n++; end
            chk("obs_ready_low_cycles", n, 6);
        end
    endtask

    task automatic run_out(input logic [3:0] pat);
        int n = 0;
        int h0;
        h0 = hs_cnt;
        for (int g = 0; g < G; g++) got[g] = 8'hEE;
        out_ready = 1'b0;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk("out_valid_seen", out_valid, 1);
        n = 0;
        while (busy && n < 40) begin
            out_ready = pat[n % 4];
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("out_phase_end", busy, 0);
        chk("handshakes", hs_cnt - h0, 4);
        chk("obs_cnt", obs_cnt, exp_cnt);
        tick();
    endtask

    // Literal packed as {w3,w2,w1,w0}.
    task automatic check_words(input string tag, input logic [31:0] lit);
        logic [31:0] v;
        v = lit;
        for (int g = 0; g < G; g++) begin
            chk($sformatf("%s_word%0d", tag, g), got[g], v[8*g +: 8]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < G; g++) begin exp_map[g] = '0; got[g] = '0; end
        fork
            monitor();
        join_none

        repeat (2) tick();
        reset_check("por");
        rst_n = 1'b1;
        tick();

        // 1: reset in the middle of SCAN, then a non-blocking code gives an all-zero map.
        do_start();
        send_obs(15'h4003, 1'b1);
        tick();
        rst_n = 1'b0;
        #2;
        reset_check("midscan");
        for (int g = 0; g < G; g++) exp_map[g] = '0;
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("busy_after_reset", busy, 0);
        do_start();
        send_obs(15'h0005, 1'b1);
        run_out(4'b1111);
        check_words("t1", 32'h00000000);

        // 2: single blocking code.
        do_start();
        send_obs(15'h4003, 1'b1);
        run_out(4'b1111);
        check_words("t2", 32'h00010203);

        // 3: OR accumulation across two codes.
        do_start();
        send_obs(15'h4010, 1'b0);
        send_obs(15'h4001, 1'b1);
        run_out(4'b1111);
        check_words("t3", 32'h13131111);

        // 4: stalled sink, ready pattern 1,0,0,1.
        do_start();
        send_obs(15'h4003, 1'b1);
        run_out(4'b1001);
        check_words("t4", 32'h00010203);

        // 5: abort in the second SCAN cycle; its returns land after a fresh start and must be dropped.
        do_start();
        send_obs(15'h4003, 1'b1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        do_start();
        send_obs(15'h4000, 1'b1);
        run_out(4'b1111);
        check_words("t5", 32'h03020100);

        // 6: start+abort together stays IDLE; start in WAIT_OBS neither clears nor restarts.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        chk("start_abort_busy", busy, 0);
        chk("start_abort_cnt", obs_cnt, exp_cnt);
        do_start();
        send_obs(15'h4010, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_wait_busy", busy, 1);
        chk("start_in_wait_ready", obs_ready, 1);
        chk("start_in_wait_cnt", obs_cnt, 1);
        send_obs(15'h4001, 1'b1);
        run_out(4'b1111);
        check_words("t6", 32'h13131111);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
